btn_debounce_bank: RTL and testbench

Input conditioner for the iCEBreaker push-buttons: synchronises raw button pins into the `clk` domain, removes contact bounce, normalises polarity to active-high, and emits a debounced level plus single-cycle press/release strobes per button. It sits between the input SB_IO cells (D_IN_0) and user logic. It is the read-side counterpart of the LED output path.

---
 rtl/btn_pkg.sv | 25 ++
 rtl/btn_debounce_chan.sv | 139 +++++++++++++
 rtl/btn_debounce_bank.sv | 53 +++++
 tb/tb_btn_debounce_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_pkg
//  Purpose  : Shared definitions for the push-button input conditioner:
//             debounce FSM state encoding and default 12 MHz timing counts.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Debounce FSM states. UP/DOWN are the stable levels, CHK_* are the
    // qualification windows while a change is being confirmed.
    typedef enum logic [1:0] {
        ST_UP     = 2'd0,
        ST_CHK_DN = 2'd1,
        ST_DOWN   = 2'd2,
        ST_CHK_UP = 2'd3
    } btn_state_t;

    // 10 ms and 1 s at a 12 MHz system clock.
    localparam int DEF_DEBOUNCE_CYCLES = 120000;
    localparam int DEF_LONG_CYCLES     = 12000000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_chan
//  Purpose  : One button channel: 2-flop synchroniser, 4-state debounce FSM
//             and (optionally) a long-press hold counter.
//  Ports    : clk        - system clock
//             resetn     - asynchronous active-low reset
//             pin        - polarity-corrected raw pin (1 = pressed), async
//             level      - debounced pressed state (registered)
//             press      - one-cycle strobe on level rising
//             rel        - one-cycle strobe on level falling
//             long_press - one-cycle strobe at the long-press threshold
//  Config   : BTN_LONG_PRESS_EN enables the hold counter; otherwise
//             long_press is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_press
);

    localparam int               CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("btn_debounce_chan: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic          s1;
    logic          s2;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    // Synchroniser and FSM share one process so every output stays registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_UP;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                ST_UP: begin
                    if (s2) begin
                        state <= ST_CHK_DN;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_CHK_DN: begin
                    if (!s2) begin
                        // bounce: abandon and restart the count next time
                        state <= ST_UP;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_DOWN;
                        level <= 1'b1;
                        press <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (!s2) begin
                        state <= ST_CHK_UP;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_CHK_UP: begin
                    if (s2) begin
                        state <= ST_DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_UP;
                        level <= 1'b0;
                        rel   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_UP;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int            HW        = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold;
    logic          long_q;

    // Saturating at LONG_CYCLES means the FIRE value is passed exactly once
    // per press. Gating with level suppresses a strobe after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= level && (hold == HOLD_FIRE);
            if (!level) begin
                hold <= '0;
            end else if ((state == ST_DOWN || state == ST_CHK_UP) && hold != HOLD_MAX) begin
                hold <= hold + 1'b1;
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_bank
//  Purpose  : Input conditioner for N_BTN push-buttons. Normalises polarity
//             to active-high and debounces each channel independently.
//  Ports    : clk         - system clock
//             resetn      - asynchronous active-low reset
//             btn_raw     - raw pin levels from SB_IO D_IN_0 (async)
//             btn_level   - debounced active-high pressed state
//             btn_press   - one-cycle strobe per rising btn_level
//             btn_release - one-cycle strobe per falling btn_level
//             btn_long    - one-cycle long-press strobe (0 if compiled out)
//  Config   : BTN_LONG_PRESS_EN adds a per-channel long-press hold counter.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 3,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = N_BTN'(1),
    parameter int               LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    // After this XOR every channel reads 1 when pressed.
    logic [N_BTN-1:0] s0;
    assign s0 = btn_raw ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk        (clk),
            .resetn     (resetn),
            .pin        (s0[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .rel        (btn_release[i]),
            .long_press (btn_long[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_debounce_bank
//  Purpose  : Directed self-checking bench for btn_debounce_bank with
//             DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW_MASK=3'b001.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_bank;

    localparam int N_BTN   = 3;
    localparam int DEB     = 4;
    localparam int LONGC   = 10;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             resetn  = 1'b0;
    logic [N_BTN-1:0] btn_raw = 3'b001;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    int passed = 0;
    int total  = 0;

    btn_debounce_bank #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW_MASK (3'b001),
        .LONG_CYCLES     (LONGC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns past the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {level, press, release, long} against the expected nibbles.
    task automatic expect_out(input string tag, input logic [2:0] lv, input logic [2:0] pr,
                              input logic [2:0] rl, input logic [2:0] lg);
        logic [11:0] obs;
        logic [11:0] exp_v;
        obs   = {btn_level, btn_press, btn_release, btn_long};
        exp_v = {lv, pr, rl, lg};
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed lvl/prs/rel/lng=%03h expected %03h", tag, obs, exp_v);
    endtask

    // Holds channel ch pressed for 'hold' cycles (starting from idle), then
    // releases and runs until the release strobe has passed.
    task automatic hold_run(input string tag, input int ch, input int hold, input int long_k);
        logic [2:0] m;
        logic [2:0] lv;
        logic [2:0] pr;
        logic [2:0] rl;
        logic [2:0] lg;
        m = 3'b001 << ch;
        btn_raw = btn_raw ^ m;
        for (int k = 1; k <= hold + 8; k++) begin
            step();
            lv = (k >= DEB + 2 && k < hold + DEB + 2) ? m : 3'b000;
            pr = (k == DEB + 2) ? m : 3'b000;
            rl = (k == hold + DEB + 2) ? m : 3'b000;
            lg = (LONG_EN && k == long_k) ? m : 3'b000;
            expect_out(tag, lv, pr, rl, lg);
            if (k == hold) btn_raw = btn_raw ^ m;
        end
    endtask

    initial begin
        // ---- reset with all pins inactive
        resetn  = 1'b0;
        btn_raw = 3'b001;
        repeat (3) step();
        expect_out("reset_state", 3'b000, 3'b000, 3'b000, 3'b000);
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            expect_out("idle_after_reset", 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // ---- clean press/release on active-high channel 1
        hold_run("ch1_clean", 1, 8, 0);

        // ---- minimum accepted press on active-low channel 0
        hold_run("ch0_min_hold", 0, 4, 0);

        // ---- bounce on channel 2: 3-cycle pulses are rejected
        for (int p = 0; p < 4; p++) begin
            btn_raw[2] = (p % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                step();
                expect_out("ch2_bounce", 3'b000, 3'b000, 3'b000, 3'b000);
            end
        end
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            expect_out("ch2_after_bounce", (k >= 6) ? 3'b100 : 3'b000,
                       (k == 6) ? 3'b100 : 3'b000, 3'b000, 3'b000);
        end
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            expect_out("ch2_release", (k < 6) ? 3'b100 : 3'b000, 3'b000,
                       (k == 6) ? 3'b100 : 3'b000, 3'b000);
        end

        // ---- simultaneous press on ch0 (active-low) and ch2
        btn_raw = 3'b100;
        for (int k = 1; k <= 7; k++) begin
            step();
            expect_out("simul_press", (k >= 6) ? 3'b101 : 3'b000,
                       (k == 6) ? 3'b101 : 3'b000, 3'b000, 3'b000);
        end
        btn_raw = 3'b001;
        for (int k = 1; k <= 7; k++) begin
            step();
            expect_out("simul_release", (k < 6) ? 3'b101 : 3'b000, 3'b000,
                       (k == 6) ? 3'b101 : 3'b000, 3'b000);
        end

        // ---- reset mid-debounce aborts; held button is a fresh press
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_out("pre_reset_debounce", 3'b000, 3'b000, 3'b000, 3'b000);
        end
        resetn = 1'b0;
        #1;
        expect_out("reset_mid_debounce", 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out("in_reset", 3'b000, 3'b000, 3'b000, 3'b000);
        end
        resetn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            expect_out("press_after_reset", (k >= 6) ? 3'b010 : 3'b000,
                       (k == 6) ? 3'b010 : 3'b000, 3'b000, 3'b000);
        end
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            expect_out("release_after_reset", (k < 6) ? 3'b010 : 3'b000, 3'b000,
                       (k == 6) ? 3'b010 : 3'b000, 3'b000);
        end

        // ---- long press: 30-cycle hold fires once 10 cycles after press;
        //      7-cycle hold never fires
        hold_run("ch1_long_hold", 1, 30, DEB + 2 + LONGC);
        hold_run("ch1_short_hold", 1, 7, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
